// File: rtl/fq_generate_if.sv
// rtl/fq_generate_if.sv - frequency request handshake and status bundle
// Ports:
//   set_freq     requested frequency in Hz
//   set_valid    request strobe
//   set_ready    generator can take a request
//   set_err      last request was out of range (sticky)
//   current_freq last frequency actually applied
interface fq_generate_if;
    logic [31:0] set_freq;
    logic        set_valid;
    logic        set_ready;
    logic        set_err;
    logic [31:0] current_freq;

    modport master (
        output set_freq, set_valid,
        input  set_ready, set_err, current_freq
    );

    modport slave (
        input  set_freq, set_valid,
        output set_ready, set_err, current_freq
    );
endinterface

// File: rtl/fq_generate.sv
// rtl/fq_generate.sv - programmable square-wave generator driven by a phase accumulator
// Ports:
//   Clock    reference clock (REF_FREQ Hz), rising edge
//   Reset    synchronous, active-high
//   bus      request/status bundle (slave side)
//   freq_out registered accumulator MSB, the generated square wave
module fq_generate #(
    parameter int REF_FREQ = 1000000,
    parameter int ACC_W    = 32
) (
    input  logic          Clock,
    input  logic          Reset,
    fq_generate_if.slave  bus,
    output logic          freq_out
);

    // Remainder never reaches REF_FREQ, so one spare bit holds the shifted value.
    localparam int REM_W = $clog2(REF_FREQ) + 1;
    localparam int CNT_W = $clog2(ACC_W + 1);

    localparam logic [31:0]      HALF_FREQ = 32'(REF_FREQ / 2);
    localparam logic [REM_W:0]   REF_CMP   = (REM_W + 1)'(REF_FREQ);
    localparam logic [CNT_W-1:0] LAST_IT   = CNT_W'(ACC_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        APPLY  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] quo;
    logic [REM_W-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      target;
    logic             err_q;
    logic [31:0]      cur_q;

    logic             accept;
    logic             in_range;
    logic [REM_W:0]   rem_sh;
    logic             take;
    logic [REM_W-1:0] rem_next;

    assign accept   = bus.set_valid && bus.set_ready;
    assign in_range = (bus.set_freq <= HALF_FREQ);

    // One restoring-division step per DIVIDE cycle.
    assign rem_sh   = {rem, 1'b0};
    assign take     = (rem_sh >= REF_CMP);
    assign rem_next = take ? REM_W'(rem_sh - REF_CMP) : REM_W'(rem_sh);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && in_range) state_next = DIVIDE;
            DIVIDE:  if (cnt == LAST_IT)     state_next = APPLY;
            APPLY:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.set_ready    = (state == IDLE);
        bus.set_err      = err_q;
        bus.current_freq = cur_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            acc      <= '0;
            inc_q    <= '0;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
            target   <= '0;
            err_q    <= 1'b0;
            cur_q    <= '0;
            freq_out <= 1'b0;
        end else begin
            // The old increment keeps running through DIVIDE so the output
            // stays clean until the new setting lands in APPLY.
            acc      <= acc + inc_q;
            freq_out <= acc[ACC_W-1];
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_range) begin
                            err_q  <= 1'b0;
                            target <= bus.set_freq;
                            rem    <= REM_W'(bus.set_freq);
                            quo    <= '0;
                            cnt    <= '0;
                        end else begin
                            err_q  <= 1'b1;
                        end
                    end
                end
                DIVIDE: begin
                    rem <= rem_next;
                    quo <= {quo[ACC_W-2:0], take};
                    cnt <= cnt + 1'b1;
                end
                APPLY: begin
                    inc_q <= quo;
                    acc   <= '0;
                    cur_q <= target;
                end
                default: ;
            endcase
        end
    end

endmodule
